// File: rtl/bus_slave_router_if.sv
// Core-side request/response bus of the slave router.
interface bus_slave_router_if;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        m_err;

    // Core side: issues requests, receives completions.
    modport master (
        output m_req, m_we, m_addr, m_wdata, m_wstrb,
        input  m_ready, m_rdata, m_err
    );

    // Router side: accepts requests, returns completions.
    modport slave (
        input  m_req, m_we, m_addr, m_wdata, m_wstrb,
        output m_ready, m_rdata, m_err
    );
endinterface

// File: rtl/bus_slave_router.sv
// Single-master to three-slave router: memory (0x0), GPIO (0x4), I2C (0x5).
// Unmapped addresses and hung slaves complete with an error response.
module bus_slave_router #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    bus_slave_router_if.slave         m_bus,
    output logic                      busy,
    output logic [31:0]               s_addr,
    output logic [31:0]               s_wdata,
    output logic                      s_we,
    output logic [3:0]                s_wstrb,
    output logic                      s0_req,
    output logic                      s1_req,
    output logic                      s2_req,
    input  logic                      s0_ready,
    input  logic                      s1_ready,
    input  logic                      s2_ready,
    input  logic [31:0]               s0_rdata,
    input  logic [31:0]               s1_rdata,
    input  logic [31:0]               s2_rdata
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    sel_q;
    logic [2:0]    sel_dec;
    logic [CW-1:0] cnt_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic          sel_ready;
    logic [31:0]   sel_rdata;
    logic          timeout;

    // Address map decode and selected-slave response mux.
    always_comb begin
        sel_dec = '0;
        case (m_bus.m_addr[31:28])
            4'h0:    sel_dec = 3'b001;
            4'h4:    sel_dec = 3'b010;
            4'h5:    sel_dec = 3'b100;
            default: sel_dec = '0;
        endcase
        sel_ready = |(sel_q & {s2_ready, s1_ready, s0_ready});
        sel_rdata = ({32{sel_q[0]}} & s0_rdata)
                  | ({32{sel_q[1]}} & s1_rdata)
                  | ({32{sel_q[2]}} & s2_rdata);
        timeout   = (cnt_q == CNT_LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a ready in the last timeout cycle still wins.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m_bus.m_req) begin
                    state_nxt = (sel_dec != '0) ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (sel_ready || timeout) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, timeout counter and completion data registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_addr  <= '0;
            s_wdata <= '0;
            s_we    <= 1'b0;
            s_wstrb <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_bus.m_req) begin
                        s_addr  <= m_bus.m_addr;
                        s_wdata <= m_bus.m_wdata;
                        s_we    <= m_bus.m_we;
                        s_wstrb <= m_bus.m_wstrb;
                        sel_q   <= sel_dec;
                        cnt_q   <= '0;
                        rdata_q <= ERR_RDATA;
                        err_q   <= (sel_dec == '0);
                    end
                end
                ACCESS: begin
                    if (sel_ready) begin
                        rdata_q <= s_we ? '0 : sel_rdata;
                        err_q   <= 1'b0;
                    end else if (timeout) begin
                        rdata_q <= ERR_RDATA;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state; completion fields are zero outside RESP.
    always_comb begin
        m_bus.m_ready = (state == RESP);
        m_bus.m_rdata = (state == RESP) ? rdata_q : '0;
        m_bus.m_err   = (state == RESP) ? err_q : 1'b0;
        busy          = (state != IDLE);
        s0_req        = (state == ACCESS) && sel_q[0];
        s1_req        = (state == ACCESS) && sel_q[1];
        s2_req        = (state == ACCESS) && sel_q[2];
    end

endmodule

// File: doc/bus_slave_router.md
Name: bus_slave_router

Overview:
- Single-master to three-slave transaction router for the SoC system bus. It sits directly downstream of the address decoder.
- Per request it decodes addr[31:28] with the same map: 0x0 = memory (s0), 0x4 = GPIO (s1), 0x5 = I2C (s2).
- It registers the request, drives exactly one slave request and waits for that slave's ready. It then returns read data or an error to the core.
- Unmapped addresses and hung slaves complete with an error response, so the core never stalls forever.

Parameters:
- TIMEOUT_CYCLES, 255: max ACCESS cycles before forced error completion (≥2).
- ERR_RDATA, 32'h0000_0000: m_rdata value on any error completion.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- m_req  in  1  master request; sampled only in IDLE.
- m_we  in  1  1 = write, 0 = read.
- m_addr  in  32  byte address.
- m_wdata  in  32  write data.
- m_wstrb  in  4  byte strobes.
- m_ready  out  1  one-cycle completion pulse.
- m_rdata  out  32  read data; valid when m_ready=1.
- m_err  out  1  error flag; valid when m_ready=1.
- busy  out  1  high in ACCESS or RESP.
- s_addr  out  32  registered address, shared by all slaves.
- s_wdata  out  32  registered write data, shared.
- s_we  out  1  registered write enable, shared.
- s_wstrb  out  4  registered strobes, shared.
- s0_req, s1_req, s2_req  out  1 each  per-slave request; held until completion.
- s0_ready, s1_ready, s2_ready  in  1 each  slave done pulse.
- s0_rdata, s1_rdata, s2_rdata  in  32 each  slave read data; valid with the matching ready.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, timeout counter=0.
  - All outputs 0, including s_addr, s_wdata, s_we and s_wstrb.
  - Any in-flight transaction is aborted with no m_ready; sN_req drops at the next edge.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, m_req=1 at edge T:
  - Capture addr/wdata/we/wstrb into the s_* registers.
  - Latch a one-hot select; clear the counter.
  - Mapped address: go to ACCESS. From T+1, only the selected sN_req=1.
  - Unmapped address: go directly to RESP with an error completion. No sN_req ever asserts.
- ACCESS:
  - Only the ready of the selected slave is observed. The other two readies and rdatas are ignored.
  - Selected ready=1: capture its rdata (reads) or 0 (writes); m_err=0; go to RESP.
  - Ready absent and counter==TIMEOUT_CYCLES-1: go to RESP with m_err=1 and m_rdata=ERR_RDATA.
  - Ready absent otherwise: counter+1.
  - Ready wins over timeout when both occur in the same cycle.
  - sN_req stays high for the whole of ACCESS and is 0 in RESP.
- RESP:
  - m_ready=1 for exactly one cycle, with registered m_rdata and m_err.
  - Next state is always IDLE. m_ready, m_err and m_rdata return to 0 in IDLE.
- Latency:
  - Slave ready at cycle T+k (k≥1): m_ready at T+k+1.
  - Unmapped address: m_ready at T+1.
  - Timeout: ACCESS lasts TIMEOUT_CYCLES cycles; m_ready at T+TIMEOUT_CYCLES+1.
- Master contract:
  - The master holds its request until it sees m_ready.
  - If m_req is still high in the first IDLE cycle after RESP, a new transaction starts, so back-to-back accesses cost one idle cycle.
  - m_req, m_addr and the other m_* inputs are ignored in ACCESS and RESP.
- One-hot guarantee: at most one sN_req is high in any cycle.
- Counter width is clog2(TIMEOUT_CYCLES) and it never wraps.
- s_* registers hold their last value in IDLE and reset to 0.

Test Plan:
1. Memory read:
   - Stimulus: m_req with m_addr=0x0000_0010, we=0 at T; s0_ready pulse at T+3 with rdata 0x1234_5678.
   - Required: s0_req high T+1..T+3; m_ready at T+4 with rdata 0x1234_5678 and err=0; s1_req and s2_req stay 0.
2. GPIO write:
   - Stimulus: m_addr=0x4000_0004, wdata=0xA5, wstrb=4'b0001, we=1; s1_ready at T+1.
   - Required: s_addr=0x4000_0004 and s_wstrb=1 from T+1; m_ready at T+2 with rdata 0 and err=0.
3. Unmapped address:
   - Stimulus: m_addr=0x8000_0000.
   - Required: no sN_req ever asserts; m_ready at T+1 with err=1 and rdata=ERR_RDATA.
4. Timeout:
   - Stimulus: TIMEOUT_CYCLES=16, m_addr=0x5000_0000, s2_ready held 0.
   - Required: s2_req high T+1..T+16; m_ready/err=1 at T+17; busy drops at T+18.
   - Rerun with s2_ready at T+16: required err=0 (ready wins over timeout).
5. Stray ready:
   - Stimulus: I2C access in progress; s0_ready=1 with rdata 0xFFFF_FFFF.
   - Required: ignored, no completion; the later s2_ready completes normally with s2 data.
6. Reset mid-ACCESS:
   - Stimulus: rst_n=0 during a memory access.
   - Required: all outputs 0 next edge and no m_ready. After release, a fresh request at 0x0000_0000 completes normally.
